// File: rtl/lm75_poll_ctrl.sv
// rtl/lm75_poll_ctrl.sv - I2C master polling an LM75 temperature sensor (optional AUTO_POLL_EN)
module lm75_poll_ctrl #(
  parameter int         CLK_DIV       = 4,
  parameter logic [6:0] DEV_ADDR      = 7'h48,
  parameter int         POLL_INTERVAL = 100000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Start,
  input  logic       Sda_in,
  output logic       Sda_oe,
  output logic       Scl_oe,
  output logic [8:0] Temp,
  output logic       Temp_valid,
  output logic       Busy,
  output logic       Nack_err
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  // Reject configurations the quarter-slot timing cannot honour.
  if (CLK_DIV < 2 || POLL_INTERVAL < 1) begin : g_bad_cfg
    $error("lm75_poll_ctrl: CLK_DIV must be >= 2 and POLL_INTERVAL >= 1");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR_W, S_ACK1, S_PTR, S_ACK2, S_RSTART,
    S_ADDR_R, S_ACK3, S_RD_MSB, S_MACK, S_RD_LSB, S_MNACK, S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [1:0]      qtr_q, qtr_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic [7:0]      msb_q, msb_d;
  logic            err_q, err_d;
  logic [8:0]      temp_q, temp_d;
  logic            temp_valid_q, temp_valid_d;
  logic            nack_err_q, nack_err_d;
  logic            busy_q, busy_d;
  logic            sda_oe_q, sda_oe_d;
  logic            scl_oe_q, scl_oe_d;

  logic qtr_end, slot_end, sample, start_req;

  assign qtr_end  = (div_q == DIV_LAST);
  assign slot_end = qtr_end && (qtr_q == 2'd3);
  // Sda_in is taken on the last cycle of q2, while SCL is still high.
  assign sample   = qtr_end && (qtr_q == 2'd2);

`ifdef AUTO_POLL_EN
  localparam int PW = $clog2(POLL_INTERVAL + 1);
  logic [PW-1:0] poll_q, poll_d;
  assign start_req = Start | (poll_q == '0);
`else
  assign start_req = Start;
`endif

  // Next-state, datapath and registered bus-pin values for the whole transaction.
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    qtr_d        = qtr_q;
    bit_d        = bit_q;
    sh_d         = sh_q;
    msb_d        = msb_q;
    err_d        = err_q;
    temp_d       = temp_q;
    temp_valid_d = 1'b0;
    nack_err_d   = 1'b0;
`ifdef AUTO_POLL_EN
    poll_d       = poll_q;
`endif

    if (state_q != S_IDLE) begin
      div_d = qtr_end ? '0 : div_q + 1'b1;
      if (qtr_end) qtr_d = qtr_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          state_d = S_START;
          div_d   = '0;
          qtr_d   = 2'd0;
          bit_d   = 3'd0;
          err_d   = 1'b0;
        end
`ifdef AUTO_POLL_EN
        else begin
          poll_d = poll_q - 1'b1;
        end
`endif
      end
      S_START: begin
        if (slot_end) begin
          state_d = S_ADDR_W;
          sh_d    = {DEV_ADDR, 1'b0};
        end
      end
      S_ADDR_W, S_PTR, S_ADDR_R: begin
        if (slot_end) begin
          sh_d  = {sh_q[6:0], 1'b0};
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
            case (state_q)
              S_ADDR_W: state_d = S_ACK1;
              S_PTR:    state_d = S_ACK2;
              default:  state_d = S_ACK3;
            endcase
          end
        end
      end
      S_ACK1, S_ACK2, S_ACK3: begin
        if (sample && Sda_in) err_d = 1'b1;
        if (slot_end) begin
          if (err_q) begin
            state_d = S_STOP;
          end else begin
            case (state_q)
              S_ACK1: begin
                state_d = S_PTR;
                sh_d    = 8'h00;
              end
              S_ACK2:  state_d = S_RSTART;
              default: state_d = S_RD_MSB;
            endcase
          end
        end
      end
      S_RSTART: begin
        if (slot_end) begin
          state_d = S_ADDR_R;
          sh_d    = {DEV_ADDR, 1'b1};
        end
      end
      S_RD_MSB, S_RD_LSB: begin
        if (sample) sh_d = {sh_q[6:0], Sda_in};
        if (slot_end) begin
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
            if (state_q == S_RD_MSB) begin
              state_d = S_MACK;
              msb_d   = sh_q;
            end else begin
              state_d = S_MNACK;
            end
          end
        end
      end
      S_MACK: begin
        if (slot_end) state_d = S_RD_LSB;
      end
      S_MNACK: begin
        if (slot_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (slot_end) begin
          state_d = S_IDLE;
          // sh_q still holds the LSB byte; only its top bit carries the half degree.
          if (err_q) begin
            nack_err_d = 1'b1;
          end else begin
            temp_d       = {msb_q, sh_q[7]};
            temp_valid_d = 1'b1;
          end
`ifdef AUTO_POLL_EN
          poll_d = PW'(POLL_INTERVAL - 1);
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d   = (state_d != S_IDLE);
    sda_oe_d = 1'b0;
    scl_oe_d = 1'b0;
    case (state_d)
      S_START, S_RSTART: sda_oe_d = qtr_d[1];
      S_STOP: begin
        scl_oe_d = (qtr_d == 2'd0);
        sda_oe_d = ~qtr_d[1];
      end
      S_ADDR_W, S_PTR, S_ADDR_R: begin
        scl_oe_d = (qtr_d == 2'd0) || (qtr_d == 2'd3);
        sda_oe_d = ~sh_d[7];
      end
      S_MACK: begin
        scl_oe_d = (qtr_d == 2'd0) || (qtr_d == 2'd3);
        sda_oe_d = 1'b1;
      end
      S_ACK1, S_ACK2, S_ACK3, S_RD_MSB, S_RD_LSB, S_MNACK:
        scl_oe_d = (qtr_d == 2'd0) || (qtr_d == 2'd3);
      default: ;
    endcase
  end

  // State and output registers; reset releases both bus lines at once.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      qtr_q        <= 2'd0;
      bit_q        <= 3'd0;
      sh_q         <= 8'h00;
      msb_q        <= 8'h00;
      err_q        <= 1'b0;
      temp_q       <= 9'h000;
      temp_valid_q <= 1'b0;
      nack_err_q   <= 1'b0;
      busy_q       <= 1'b0;
      sda_oe_q     <= 1'b0;
      scl_oe_q     <= 1'b0;
`ifdef AUTO_POLL_EN
      poll_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      qtr_q        <= qtr_d;
      bit_q        <= bit_d;
      sh_q         <= sh_d;
      msb_q        <= msb_d;
      err_q        <= err_d;
      temp_q       <= temp_d;
      temp_valid_q <= temp_valid_d;
      nack_err_q   <= nack_err_d;
      busy_q       <= busy_d;
      sda_oe_q     <= sda_oe_d;
      scl_oe_q     <= scl_oe_d;
`ifdef AUTO_POLL_EN
      poll_q       <= poll_d;
`endif
    end
  end

  assign Sda_oe     = sda_oe_q;
  assign Scl_oe     = scl_oe_q;
  assign Temp       = temp_q;
  assign Temp_valid = temp_valid_q;
  assign Busy       = busy_q;
  assign Nack_err   = nack_err_q;

endmodule

// File: tb/tb_lm75_poll_ctrl.sv
// tb/tb_lm75_poll_ctrl.sv - self-checking bench for lm75_poll_ctrl with an LM75 slave model
module tb_lm75_poll_ctrl;

  localparam int CLK_DIV  = 4;
  localparam int TXN_LEN  = 48 * 4 * CLK_DIV;
  localparam int NACK_LEN = 11 * 4 * CLK_DIV;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Start = 1'b0;
  logic       Sda_in;
  logic       Sda_oe, Scl_oe;
  logic [8:0] Temp;
  logic       Temp_valid, Busy, Nack_err;

  always #5 Clk = ~Clk;

  lm75_poll_ctrl #(.CLK_DIV(CLK_DIV), .DEV_ADDR(7'h48), .POLL_INTERVAL(1000)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Sda_in(Sda_in), .Sda_oe(Sda_oe), .Scl_oe(Scl_oe),
    .Temp(Temp), .Temp_valid(Temp_valid), .Busy(Busy), .Nack_err(Nack_err)
  );

  // Open-drain bus with pull-ups.
  logic s_drive = 1'b0;
  logic scl, sda;
  assign scl    = ~Scl_oe;
  assign sda    = ~(Sda_oe | s_drive);
  assign Sda_in = sda;

  // LM75 slave model state and bus logs.
  bit         s_present = 1'b1;
  logic [7:0] s_data [2];
  logic [1:0] s_idx = 2'd0;
  int         s_cnt = 0;
  bit         s_rd = 1'b0, s_addr_frame = 1'b0, s_go_rd = 1'b0, was_rd;
  logic [7:0] s_sh = 8'h00;
  logic [7:0] wr_log [$];
  bit         mack_log [$];
  int         n_start = 0, n_stop = 0, n_valid = 0, n_nack = 0;
  bit         prev_scl = 1'b1, prev_sda = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  always @(negedge Clk) begin
    if (Rst) begin
      s_drive = 1'b0; s_cnt = 0; s_rd = 1'b0; s_addr_frame = 1'b0; s_go_rd = 1'b0;
    end else begin
      if (prev_scl && scl && prev_sda && !sda) begin
        n_start++; s_cnt = 0; s_rd = 1'b0; s_addr_frame = 1'b1; s_go_rd = 1'b0; s_drive = 1'b0;
      end else if (prev_scl && scl && !prev_sda && sda) begin
        n_stop++; s_cnt = 0; s_rd = 1'b0; s_addr_frame = 1'b0; s_drive = 1'b0;
      end else if (!prev_scl && scl) begin
        s_cnt++;
        if (s_cnt <= 8) s_sh = {s_sh[6:0], sda};
        else if (s_rd) begin
          mack_log.push_back(sda);
          s_go_rd = !sda;
        end
      end else if (prev_scl && !scl) begin
        if (s_cnt == 8) begin
          if (s_rd) s_drive = 1'b0;
          else begin
            wr_log.push_back(s_sh);
            if (s_addr_frame) begin
              s_drive = s_present && (s_sh[7:1] == 7'h48);
              s_go_rd = s_drive && s_sh[0];
              s_idx   = 2'd0;
            end else begin
              s_drive = s_present;
              s_go_rd = 1'b0;
            end
          end
        end else if (s_cnt == 9) begin
          was_rd       = s_rd;
          s_cnt        = 0;
          s_addr_frame = 1'b0;
          s_rd         = s_go_rd;
          s_go_rd      = 1'b0;
          if (was_rd) s_idx = s_idx + 2'd1;
          s_drive = s_rd && !s_data[s_idx[0]][7];
        end else if (s_rd && s_cnt >= 1 && s_cnt <= 7) begin
          s_drive = !s_data[s_idx[0]][7 - s_cnt];
        end
      end
    end
    prev_scl = ~Scl_oe;
    prev_sda = ~(Sda_oe | s_drive);
    if (Temp_valid) n_valid++;
    if (Nack_err) n_nack++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic wait_busy(input logic level, input int max, output int n);
    n = 0;
    while (Busy !== level && n < max) begin
      @(negedge Clk);
      n++;
    end
  endtask

  // One Start pulse, then count Busy cycles and capture the falling-edge outputs.
  task automatic run_txn(input logic [7:0] msb, input logic [7:0] lsb, input bit present,
                         output int len, output logic tv_at_fall, output logic ne_at_fall);
    s_present = present;
    s_data[0] = msb;
    s_data[1] = lsb;
    wr_log.delete();
    mack_log.delete();
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    len = 0;
    while (Busy && len < 5000) begin
      len++;
      @(negedge Clk);
    end
    tv_at_fall = Temp_valid;
    ne_at_fall = Nack_err;
    @(negedge Clk);
  endtask

  // Full check of one request against the protocol-level expectation.
  task automatic txn_and_check(input string tag, input logic [7:0] msb, input logic [7:0] lsb,
                               input bit present, input logic [8:0] exp_temp);
    int len, v0, k0, st0;
    logic tv, ne;
    logic [7:0] exp_bytes [$];
    v0 = n_valid; k0 = n_nack; st0 = n_stop;
    run_txn(msb, lsb, present, len, tv, ne);
    check({tag, "_busy_len"}, len, present ? TXN_LEN : NACK_LEN);
    check({tag, "_temp"}, Temp, exp_temp);
    check({tag, "_valid_at_fall"}, tv, present);
    check({tag, "_nack_at_fall"}, ne, !present);
    check({tag, "_valid_pulses"}, n_valid - v0, present ? 1 : 0);
    check({tag, "_nack_pulses"}, n_nack - k0, present ? 0 : 1);
    check({tag, "_stops"}, n_stop - st0, 1);
    if (present) exp_bytes = '{8'h90, 8'h00, 8'h91};
    else exp_bytes = '{8'h90};
    check({tag, "_nbytes"}, wr_log.size(), exp_bytes.size());
    for (int b = 0; b < exp_bytes.size() && b < wr_log.size(); b++)
      check($sformatf("%s_byte%0d", tag, b), wr_log[b], exp_bytes[b]);
    check({tag, "_nmack"}, mack_log.size(), present ? 2 : 0);
    if (present && mack_log.size() == 2) begin
      check({tag, "_mack"}, mack_log[0], 0);
      check({tag, "_mnack"}, mack_log[1], 1);
    end
  endtask

  typedef struct {
    logic [7:0] msb;
    logic [7:0] lsb;
    bit         present;
    logic [8:0] exp_temp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int n, v0, gaps, bad_gap, low_run;
    bit seen_busy;
    logic [7:0] rm, rl;

    vecs[0] = '{8'h19, 8'h80, 1'b1, 9'h033};
    vecs[1] = '{8'h00, 8'h00, 1'b0, 9'h033};
    vecs[2] = '{8'hE7, 8'h00, 1'b1, 9'h1CE};
    vecs[3] = '{8'h7F, 8'h80, 1'b1, 9'h0FF};
    vecs[4] = '{8'h80, 8'h7F, 1'b1, 9'h100};
    vecs[5] = '{8'hFF, 8'hFF, 1'b0, 9'h100};

    repeat (3) @(negedge Clk);
    check("rst_sda_oe", Sda_oe, 0);
    check("rst_scl_oe", Scl_oe, 0);
    check("rst_temp", Temp, 0);
    check("rst_temp_valid", Temp_valid, 0);
    check("rst_busy", Busy, 0);
    check("rst_nack_err", Nack_err, 0);
    Rst = 1'b0;
    @(negedge Clk);

`ifdef AUTO_POLL_EN
    s_present = 1'b1;
    s_data[0] = 8'h19;
    s_data[1] = 8'h80;
    wait_busy(1'b1, 100, n);
    check("auto_first_start", Busy, 1);
    for (int g = 0; g < 2; g++) begin
      wait_busy(1'b0, 2000, n);
      check($sformatf("auto_end%0d", g), Busy, 0);
      wait_busy(1'b1, 3000, n);
      check($sformatf("auto_gap%0d", g), n, 1000);
    end
    check("auto_temp", Temp, 9'h033);
    check("auto_valid_seen", n_valid >= 2, 1);
`else
    for (int i = 0; i < 6; i++)
      txn_and_check($sformatf("vec%0d", i), vecs[i].msb, vecs[i].lsb, vecs[i].present, vecs[i].exp_temp);

    for (int i = 0; i < 6; i++) begin
      rm = 8'($urandom_range(0, 255));
      rl = 8'($urandom_range(0, 255));
      txn_and_check($sformatf("rnd%0d", i), rm, rl, 1'b1, {rm, rl[7]});
    end

    // Start held high: requests during Busy are dropped, next one starts after one idle cycle.
    s_present = 1'b1;
    s_data[0] = 8'h19;
    s_data[1] = 8'h80;
    v0 = 0; gaps = 0; bad_gap = 0; low_run = 0; seen_busy = 1'b0;
    @(negedge Clk);
    Start = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge Clk);
      if (Temp_valid) v0++;
      if (Busy) begin
        if (seen_busy && low_run > 0) begin
          gaps++;
          if (low_run != 1) bad_gap++;
        end
        seen_busy = 1'b1;
        low_run = 0;
      end else begin
        low_run++;
      end
    end
    Start = 1'b0;
    check("hold_completions", v0, 2);
    check("hold_gaps", gaps, 2);
    check("hold_gap_not_1", bad_gap, 0);
    wait_busy(1'b0, 1000, n);
    check("hold_drain", Busy, 0);
    @(negedge Clk);

    // Reset in the middle of the MSB read.
    s_data[0] = 8'h3C;
    s_data[1] = 8'h00;
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (500) @(negedge Clk);
    check("mid_busy", Busy, 1);
    Rst = 1'b1;
    @(negedge Clk);
    check("mid_rst_sda_oe", Sda_oe, 0);
    check("mid_rst_scl_oe", Scl_oe, 0);
    check("mid_rst_busy", Busy, 0);
    check("mid_rst_temp", Temp, 0);
    check("mid_rst_valid", Temp_valid, 0);
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    txn_and_check("after_rst", 8'h19, 8'h80, 1'b1, 9'h033);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
